// File: rtl/int_vect_ctrl.sv
// int_vect_ctrl: interrupt vector entry sequencer.
// Captures rising edges on eight request lines and arbitrates them against
// the PSW priority at instruction boundaries. It then walks a 9-step entry
// sequence (counter 0..8) for the winning source and finally acknowledges
// that source with a one-cycle irq_clear pulse.
module int_vect_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  irq,
    input  logic [2:0]  psw_prio,
    input  logic        ins_boundary,
    input  logic        step_done,
    output logic [3:0]  counter,
    output logic [15:0] iv_flags,
    output logic [15:0] vec_addr,
    output logic        iv_active,
    output logic [7:0]  irq_clear
);

    typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] irq_q;
    logic [7:0] pending;
    logic [7:0] rise;
    logic [7:0] eligible;
    logic [7:0] sel_mask;
    logic [2:0] sel;
    logic [2:0] win;
    logic       cap_en;
    logic       any_elig;
    logic       take;

    // cap_en is low for the first edge after reset. That edge only primes
    // irq_q, so lines held high across reset do not look like new requests.
    assign rise     = cap_en ? (irq & ~irq_q) : 8'h00;
    assign take     = (state == IDLE) && ins_boundary && any_elig;
    assign sel_mask = 8'h01 << sel;

    // A source is eligible when it is pending and strictly above the PSW level.
    always_comb begin
        eligible = 8'h00;
        for (int i = 0; i < 8; i++)
            eligible[i] = pending[i] && (i > int'(psw_prio));
    end

    // Pick the highest-numbered eligible source. Later iterations override earlier ones.
    always_comb begin
        win      = 3'd0;
        any_elig = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) begin
                win      = 3'(i);
                any_elig = 1'b1;
            end
        end
    end

    // Request edge capture. A new edge in the acknowledge cycle beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= 8'h00;
            cap_en  <= 1'b0;
            pending <= 8'h00;
        end else begin
            irq_q   <= irq;
            cap_en  <= 1'b1;
            pending <= (pending & ~irq_clear) | rise;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. ins_boundary only matters in IDLE, step_done only in ENTRY.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = ENTRY;
            ENTRY:   if (step_done && counter == 4'd8) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Selected source and entry step counter. sel is frozen for the whole sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= 3'd0;
            counter <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        sel     <= win;
                        counter <= 4'd0;
                    end
                end
                ENTRY:   if (step_done && counter != 4'd8) counter <= counter + 4'd1;
                DONE:    counter <= 4'd0;
                default: counter <= 4'd0;
            endcase
        end
    end

    // Outputs decode from state, so an asynchronous reset clears them at once.
    always_comb begin
        iv_active = 1'b0;
        iv_flags  = 16'h0000;
        vec_addr  = 16'h0000;
        irq_clear = 8'h00;
        case (state)
            ENTRY: begin
                iv_active = 1'b1;
                iv_flags  = {8'h00, sel_mask};
                vec_addr  = 16'hFFC0 + {11'd0, sel, 2'b00};
            end
            DONE:    irq_clear = sel_mask;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_vect_ctrl.sv
// Self-checking bench for int_vect_ctrl. The stimulus side keeps a set of
// outstanding requests and predicts which source each instruction boundary
// should pick. It queues that prediction. The monitor pops a prediction
// whenever the DUT starts an entry and checks the entry outputs and the
// closing acknowledge.
module tb_int_vect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  irq = 8'h00;
    logic [2:0]  psw_prio = 3'd0;
    logic        ins_boundary = 1'b0;
    logic        step_done = 1'b0;
    logic [3:0]  counter;
    logic [15:0] iv_flags;
    logic [15:0] vec_addr;
    logic        iv_active;
    logic [7:0]  irq_clear;

    int checks = 0;
    int failures = 0;
    logic [7:0] pend_m = 8'h00;
    int exp_q[$];

    always #5 clk = ~clk;

    int_vect_ctrl dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .psw_prio(psw_prio),
        .ins_boundary(ins_boundary), .step_done(step_done), .counter(counter),
        .iv_flags(iv_flags), .vec_addr(vec_addr), .iv_active(iv_active),
        .irq_clear(irq_clear)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: an entry start consumes one prediction, and the acknowledge must name it.
    int cur_sel = 0;
    bit in_entry = 1'b0;
    bit act_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            act_prev = 1'b0;
            in_entry = 1'b0;
        end else begin
            if (iv_active && !act_prev) begin
                if (exp_q.size() == 0) begin
                    chk("entry_unexpected", 32'd1, 32'd0);
                end else begin
                    cur_sel  = exp_q.pop_front();
                    in_entry = 1'b1;
                    chk("entry_flags", iv_flags, 32'd1 << cur_sel);
                    chk("entry_vec", vec_addr, 32'hFFC0 + 4 * cur_sel);
                    chk("entry_cnt0", counter, 32'd0);
                end
            end else if (iv_active) begin
                chk("flags_hold", iv_flags, 32'd1 << cur_sel);
                chk("vec_hold", vec_addr, 32'hFFC0 + 4 * cur_sel);
            end
            if (irq_clear != 8'h00 || (in_entry && !iv_active)) begin
                chk("done_clear", irq_clear, in_entry ? (32'd1 << cur_sel) : 32'd0);
                chk("done_flags", iv_flags, 32'd0);
                in_entry = 1'b0;
            end
            act_prev = iv_active;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive the request lines. Every 0->1 transition becomes an outstanding request.
    task automatic set_irq(input logic [7:0] v);
        pend_m = pend_m | (v & ~irq);
        irq    = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_counter", counter, 32'd0);
        chk("rst_flags", iv_flags, 32'd0);
        chk("rst_vec", vec_addr, 32'd0);
        chk("rst_active", iv_active, 32'd0);
        chk("rst_clear", irq_clear, 32'd0);
        pend_m = 8'h00;
        exp_q.delete();
        ins_boundary = 1'b0;
        step_done = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
    endtask

    // One instruction boundary plus, if something is accepted, the full entry walk.
    // The winner is the highest outstanding source above prio.
    task automatic run_entry(input logic [2:0] prio, input bit rnd, input logic [7:0] mid,
                             input bit setwin, input bit rst4);
        int s = -1;
        for (int i = 0; i < 8; i++)
            if (pend_m[i] && i > int'(prio)) s = i;
        psw_prio = prio;
        ins_boundary = 1'b1;
        step_done = 1'b0;
        if (s >= 0) exp_q.push_back(s);
        cyc();
        ins_boundary = 1'b0;
        if (s < 0) begin
            cyc();
            chk("masked_idle", iv_active, 32'd0);
            chk("masked_flags", iv_flags, 32'd0);
            return;
        end
        chk("entry_active", iv_active, 32'd1);
        for (int k = 0; k <= 8; k++) begin
            if (rst4 && k == 4) begin
                do_reset();
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                if (rnd) set_irq(8'($urandom));
                psw_prio = 3'($urandom);
                ins_boundary = 1'($urandom);
                cyc();
                chk("cnt_hold", counter, k);
            end
            ins_boundary = 1'b0;
            if (rnd) set_irq(8'($urandom));
            if (k == 3) set_irq(irq | mid);
            if (k == 8 && setwin) set_irq(irq & ~(8'd1 << s));
            step_done = 1'b1;
            cyc();
            step_done = 1'b0;
            if (k == 3) set_irq(irq & ~mid);
            if (k < 8) chk("cnt_step", counter, k + 1);
        end
        // Acknowledge cycle: the request is retired unless it rises again right now.
        pend_m[s] = 1'b0;
        if (setwin) set_irq(irq | (8'd1 << s));
        else if (rnd) set_irq(8'($urandom));
        cyc();
        chk("idle_active", iv_active, 32'd0);
        chk("idle_clear", irq_clear, 32'd0);
    endtask

    task automatic pulse(input logic [7:0] m);
        set_irq(m);
        cyc();
        set_irq(8'h00);
        cyc();
    endtask

    initial begin
        #1;
        do_reset();

        // Single request on source 3.
        pulse(8'h08);
        run_entry(3'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Sources 2 and 6 against level 3: 6 wins, and 2 waits for a lower level.
        pulse(8'h44);
        run_entry(3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
        run_entry(3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
        run_entry(3'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Masking: level 7 blocks everything, and level 5 admits only 7 and 6.
        pulse(8'hFF);
        run_entry(3'd7, 1'b0, 8'h00, 1'b0, 1'b0);
        run_entry(3'd5, 1'b0, 8'h00, 1'b0, 1'b0);
        run_entry(3'd5, 1'b0, 8'h00, 1'b0, 1'b0);
        run_entry(3'd5, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (5) run_entry(3'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // No preemption: source 7 arrives mid-entry on source 1.
        do_reset();
        pulse(8'h02);
        run_entry(3'd0, 1'b0, 8'h80, 1'b0, 1'b0);
        run_entry(3'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // A new edge on the serviced source during its acknowledge keeps it pending.
        pulse(8'h10);
        run_entry(3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        set_irq(8'h00);
        cyc();
        run_entry(3'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset at counter 4 with the line still high: nothing is re-captured afterwards.
        set_irq(8'h20);
        cyc();
        run_entry(3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        run_entry(3'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic.
        repeat (60) begin
            repeat ($urandom_range(0, 3)) begin
                set_irq(8'($urandom));
                step_done = 1'($urandom);
                psw_prio = 3'($urandom);
                cyc();
            end
            step_done = 1'b0;
            run_entry(3'($urandom_range(0, 6)), 1'b1, 8'h00, 1'($urandom),
                      $urandom_range(0, 9) == 0);
        end

        repeat (3) cyc();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_vect_ctrl.md
INT_VECT_CTRL -- requirements
Module: int_vect_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 irq  in  8  device interrupt request lines; source i has fixed priority i, 7 highest.
REQ-005 psw_prio  in  3  current PSW priority field.
REQ-006 ins_boundary  in  1  one-cycle pulse when the CPU is at an instruction boundary.
REQ-007 step_done  in  1  one-cycle pulse when the CPU completes the current entry step.
REQ-008 counter  out  4  entry step index 0..8, driven to the vector-entry decoder.
REQ-009 iv_flags  out  16  one-hot selected vector, bit i for source i; bits 15:8 always 0; all-zero when not in entry.
REQ-010 vec_addr  out  16  vector table address of the selected source.
REQ-011 iv_active  out  1  high while an entry sequence is in progress.
REQ-012 irq_clear  out  8  one-cycle one-hot acknowledge to the serviced source.

Function
REQ-013 Request capture: irq SHALL be registered each cycle (irq_q); a 0->1 transition on irq[i] SHALL set pending[i] on the next edge; pending[i] SHALL stay set until cleared per REQ-020.
REQ-014 Eligibility: source i SHALL be eligible when pending[i]=1 and i > psw_prio; with psw_prio=7, no source SHALL be eligible.
REQ-015 States: IDLE, ENTRY, DONE.
REQ-016 IDLE->ENTRY: when ins_boundary=1 and at least one source is eligible, the highest-numbered eligible source SHALL be latched as sel; on the next cycle, state=ENTRY, counter=0, iv_active=1, iv_flags=1<<sel, vec_addr=16'hFFC0+4*sel.
REQ-017 In IDLE, step_done SHALL be ignored, and ins_boundary with no eligible source SHALL cause no state change.
REQ-018 ENTRY: each step_done SHALL increment counter by 1 on the next edge; without step_done, counter SHALL hold; sel, iv_flags and vec_addr SHALL be constant throughout ENTRY.
REQ-019 ENTRY->DONE: step_done while counter=8 SHALL move to DONE; counter SHALL NOT exceed 8 or wrap.
REQ-020 DONE (exactly one cycle): irq_clear[sel]=1, pending[sel] cleared, iv_active=0, iv_flags=0, then IDLE; a new rising edge on irq[sel] in the same cycle SHALL win, leaving pending[sel]=1.
REQ-021 ins_boundary during ENTRY or DONE SHALL be ignored; new edges on any source SHALL still set pending.
REQ-022 A higher-priority request arriving during ENTRY SHALL NOT preempt; it is arbitrated at the next ins_boundary in IDLE.
REQ-023 psw_prio SHALL be sampled only at the IDLE->ENTRY decision.
REQ-024 irq_clear SHALL be 0 in every state other than DONE.

Reset
REQ-025 With rst_n=0, outputs SHALL be forced immediately, without waiting for a clock edge: state=IDLE, pending=0, irq_q=0, sel=0, counter=0, iv_flags=0, vec_addr=0, iv_active=0, irq_clear=0.
REQ-026 Reset asserted mid-ENTRY SHALL abandon the sequence without pulsing irq_clear; requests still high after reset release SHALL NOT be captured until a fresh 0->1 edge.

Verification
REQ-027 Single request: psw_prio=0, pulse irq[3], then ins_boundary -> next cycle iv_flags=16'h0008, vec_addr=16'hFFCC, counter=0; 9 step_done pulses -> counter 1..8, then DONE with irq_clear=8'h08, then IDLE.
REQ-028 Priority: pending[2] and pending[6] both set, psw_prio=3, ins_boundary -> iv_flags=16'h0040, vec_addr=16'hFFD8; source 2 remains pending.
REQ-029 Masking: psw_prio=7 with all sources pending, ins_boundary -> stays IDLE, iv_active=0; with psw_prio=5, only sources 6 and 7 are accepted.
REQ-030 No preemption: during ENTRY on source 1, pulse irq[7] -> sel stays 1 to DONE; the next ins_boundary enters source 7.
REQ-031 Set-wins: edge on irq[sel] in the DONE cycle -> pending[sel]=1 after DONE.
REQ-032 Reset mid-entry: rst_n low at counter=4 -> all outputs 0 asynchronously; irq_clear never pulses.
